uart_cal_core: RTL and testbench
================================

Name: uart_cal_core

Overview:
- Calculator engine directly downstream of the UART receiver.
- Consumes the byte stream from rx_data/rx_valid, assembles 3-byte frames (operand A, opcode, operand B), computes a 16-bit result and hands it to the transmitter as bytes over a valid/ready handshake.
- Sits between rx and tx in the UART calculator top level.

Parameters:
- TIMEOUT_CYC, 4096, idle clock cycles allowed between bytes of a partial frame before it is discarded; 0 disables the timeout.
- ERR_BYTE, 8'hEE, byte sent in place of a result when the opcode is invalid.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- rx_data  input  8  received byte, valid only when rx_valid=1
- rx_valid  input  1  one-cycle pulse per received byte
- tx_data  output  8  byte to transmit
- tx_valid  output  1  tx_data is valid; held until accepted
- tx_ready  input  1  transmitter can accept a byte
- busy  output  1  high from frame completion until the last response byte is accepted
- frame_err  output  1  one-cycle pulse on bad opcode or timeout
- ovr  output  1  one-cycle pulse when rx_valid arrives while busy; the byte is dropped

Behaviour:
- Reset (asynchronous, active-high): state=GET_A; tx_data=0, tx_valid=0, busy=0, frame_err=0, ovr=0; operand, opcode, result and timeout registers = 0.
- States: GET_A, GET_OP, GET_B, CALC, SEND_HI, SEND_LO, SEND_ERR.
- GET_A: rx_valid -> latch A, go to GET_OP.
- GET_OP: rx_valid -> latch opcode, go to GET_B.
- GET_B: rx_valid -> latch B, go to CALC. The opcode is checked here, not in GET_OP.
- CALC (1 cycle): busy=1.
  - Valid opcode: register result, go to SEND_HI.
  - Invalid opcode: pulse frame_err, go to SEND_ERR.
- Opcodes (ASCII) and 16-bit result:
  - '+' 8'h2B: A+B, zero-extended.
  - '-' 8'h2D: A-B, two's complement, sign-extended to 16 bits.
  - '*' 8'h2A: A*B, unsigned 8x8.
  - '&' 8'h26, '|' 8'h7C, '^' 8'h5E: bitwise on 8 bits, upper byte 0.
  - Any other value is invalid.
- SEND_HI: tx_valid=1, tx_data=result[15:8]. On tx_valid&tx_ready, go to SEND_LO.
- SEND_LO: tx_data=result[7:0]. On handshake, go to GET_A; tx_valid and busy drop the next cycle.
- SEND_ERR: tx_data=ERR_BYTE. On handshake, go to GET_A.
- Handshake rules:
  - tx_data must not change while tx_valid=1 and tx_ready=0.
  - tx_ready may stay low indefinitely; the core waits with no timeout.
  - A byte is accepted in exactly one cycle.
- Latency: B accepted at cycle N -> CALC at N+1 -> tx_valid=1 with the high byte at N+2. With tx_ready held at 1, the low byte is presented at N+3 and busy=0 at N+4.
- Timeout:
  - Counter clears on every accepted byte and counts in GET_OP and GET_B only.
  - When it reaches TIMEOUT_CYC with no rx_valid: pulse frame_err, discard the partial frame, go to GET_A.
  - If rx_valid arrives in the same cycle the limit is reached, the byte wins and no timeout fires.
- Bytes during CALC/SEND_*: ignored, ovr pulses for one cycle, state unchanged.
- rx_valid in the same cycle as the final tx handshake: the byte is dropped and ovr pulses. The core re-enters GET_A only on the following cycle.
- Reset mid-frame or mid-send: immediate return to reset values; a partially sent result is abandoned.

Test Plan:
- Bytes 8'h12, 8'h2B, 8'h34 with tx_ready=1 -> tx bytes 8'h00 then 8'h46; tx_valid rises 2 cycles after the third rx_valid; busy low afterwards.
- Bytes 8'h05, 8'h2D, 8'h07 -> 8'hFF then 8'hFE. Bytes 8'hFF, 8'h2A, 8'hFF -> 8'hFE then 8'h01.
- Bytes 8'h10, 8'h41, 8'h20 -> frame_err pulse in CALC, single tx byte 8'hEE, back to GET_A.
- Send 8'h12, 8'h2B, then idle TIMEOUT_CYC cycles -> frame_err pulse, no tx. Then send 8'h01, 8'h2B, 8'h01 -> 8'h00, 8'h02.
- Frame 8'hF0, 8'h26, 8'h3C with tx_ready=0 for 50 cycles and a 4th rx byte during the wait -> ovr pulse; tx_data=8'h00 stable and tx_valid=1 throughout; after tx_ready=1, second byte is 8'h30.
- Assert rst while in SEND_LO -> tx_valid=0 and busy=0 asynchronously; the next full frame computes correctly.

Source files
------------

// File: rtl/uart_cal_core.sv
// Calculator engine between the UART receiver and transmitter: assembles
// A/op/B byte frames, computes a 16-bit result and streams it out as bytes.
module uart_cal_core #(
  parameter int          TIMEOUT_CYC = 4096,
  parameter logic [7:0]  ERR_BYTE    = 8'hEE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       ovr
);

  typedef enum logic [2:0] {
    GET_A    = 3'd0,
    GET_OP   = 3'd1,
    GET_B    = 3'd2,
    CALC     = 3'd3,
    SEND_HI  = 3'd4,
    SEND_LO  = 3'd5,
    SEND_ERR = 3'd6
  } state_t;

  localparam int             CW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYC - 1);
  localparam logic           TO_EN = (TIMEOUT_CYC != 0);

  state_t        state_r;
  logic [7:0]    a_r;
  logic [7:0]    op_r;
  logic [7:0]    b_r;
  logic [15:0]   result_r;
  logic [CW-1:0] cnt_r;
  logic [15:0]   result_s;
  logic          timeout_s;

  function automatic logic op_valid(input logic [7:0] op);
    logic v;
    case (op)
      8'h2B, 8'h2D, 8'h2A, 8'h26, 8'h7C, 8'h5E: v = 1'b1;
      default:                                  v = 1'b0;
    endcase
    return v;
  endfunction

  // Subtraction is taken on 8 bits and sign-extended, so 5-7 gives 16'hFFFE.
  function automatic logic [15:0] calc(input logic [7:0] a, input logic [7:0] op,
                                       input logic [7:0] b);
    logic [15:0] r;
    logic [7:0]  d;
    d = a - b;
    case (op)
      8'h2B:   r = {8'h00, a} + {8'h00, b};
      8'h2D:   r = {{8{d[7]}}, d};
      8'h2A:   r = {8'h00, a} * {8'h00, b};
      8'h26:   r = {8'h00, a & b};
      8'h7C:   r = {8'h00, a | b};
      8'h5E:   r = {8'h00, a ^ b};
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  // Combinational result and timeout detection for the current frame.
  always_comb begin
    result_s  = calc(a_r, op_r, b_r);
    timeout_s = 1'b0;
    if (TO_EN && (cnt_r == LIMIT)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Frame assembly, calculation and byte transmit sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= GET_A;
      a_r       <= 8'h00;
      op_r      <= 8'h00;
      b_r       <= 8'h00;
      result_r  <= 16'h0000;
      cnt_r     <= '0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      ovr       <= 1'b0;
      case (state_r)
        GET_A: begin
          cnt_r <= '0;
          if (rx_valid) begin
            a_r     <= rx_data;
            state_r <= GET_OP;
          end
        end
        GET_OP: begin
          if (rx_valid) begin
            op_r    <= rx_data;
            cnt_r   <= '0;
            state_r <= GET_B;
          end else if (timeout_s) begin
            frame_err <= 1'b1;
            cnt_r     <= '0;
            state_r   <= GET_A;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        GET_B: begin
          // A byte arriving on the limit cycle takes priority over the timeout.
          if (rx_valid) begin
            b_r       <= rx_data;
            cnt_r     <= '0;
            busy      <= 1'b1;
            frame_err <= ~op_valid(op_r);
            state_r   <= CALC;
          end else if (timeout_s) begin
            frame_err <= 1'b1;
            cnt_r     <= '0;
            state_r   <= GET_A;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        CALC: begin
          ovr      <= rx_valid;
          tx_valid <= 1'b1;
          if (op_valid(op_r)) begin
            result_r <= result_s;
            tx_data  <= result_s[15:8];
            state_r  <= SEND_HI;
          end else begin
            tx_data <= ERR_BYTE;
            state_r <= SEND_ERR;
          end
        end
        SEND_HI: begin
          ovr <= rx_valid;
          if (tx_valid && tx_ready) begin
            tx_data <= result_r[7:0];
            state_r <= SEND_LO;
          end
        end
        SEND_LO, SEND_ERR: begin
          ovr <= rx_valid;
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            state_r  <= GET_A;
          end
        end
        default: begin
          state_r  <= GET_A;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cal_core.sv
// Scoreboard bench for uart_cal_core: expected tx bytes are queued as frames
// are sent and checked by a monitor as each byte is handed off.
module tb_uart_cal_core;

  localparam int T = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_err;
  logic       ovr;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  uart_cal_core #(.TIMEOUT_CYC(T), .ERR_BYTE(8'hEE)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_err(frame_err), .ovr(ovr)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL tx_unexpected: got %02h, expected no byte", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          miscompares++;
          $display("FAIL tx_byte: got %02h, expected %02h", tx_data, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0 && !tx_valid) break;
      step();
    end
    vectors++;
    if (exp_q.size() != 0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drain: got left=%0d tx_valid=%b busy=%b, expected 0 0 0",
               name, exp_q.size(), tx_valid, busy);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    vectors++;
    if ({tx_data, tx_valid, busy, frame_err, ovr} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset: got data=%02h v=%b busy=%b err=%b ovr=%b, expected all 0",
               tx_data, tx_valid, busy, frame_err, ovr);
    end
  endtask

  task automatic test_add_latency();
    tx_ready = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'h46);
    send_byte(8'h12); send_byte(8'h2B); send_byte(8'h34);
    vectors++;
    if (busy !== 1'b1 || tx_valid !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL add_calc: got busy=%b v=%b err=%b, expected 1 0 0", busy, tx_valid, frame_err);
    end
    step();
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL add_latency: got v=%b data=%02h, expected 1 00", tx_valid, tx_data);
    end
    step(); step();
    vectors++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL add_busy_drop: got busy=%b v=%b, expected 0 0", busy, tx_valid);
    end
    drain("add");
  endtask

  task automatic test_arith();
    logic [7:0]  fa [4] = '{8'h05, 8'hFF, 8'hAA, 8'h0F};
    logic [7:0]  fo [4] = '{8'h2D, 8'h2A, 8'h5E, 8'h7C};
    logic [7:0]  fb [4] = '{8'h07, 8'hFF, 8'h0F, 8'hF0};
    logic [15:0] fr [4] = '{16'hFFFE, 16'hFE01, 16'h00A5, 16'h00FF};
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(fr[i][15:8]); exp_q.push_back(fr[i][7:0]);
      send_byte(fa[i]); send_byte(fo[i]); send_byte(fb[i]);
      drain("arith");
    end
  endtask

  task automatic test_bad_opcode();
    tx_ready = 1'b1;
    exp_q.push_back(8'hEE);
    send_byte(8'h10); send_byte(8'h41); send_byte(8'h20);
    vectors++;
    if (frame_err !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL badop_err: got err=%b busy=%b, expected 1 1", frame_err, busy);
    end
    step();
    vectors++;
    if (frame_err !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'hEE) begin
      miscompares++;
      $display("FAIL badop_send: got err=%b v=%b data=%02h, expected 0 1 EE",
               frame_err, tx_valid, tx_data);
    end
    drain("badop");
  endtask

  task automatic test_timeout();
    int bad;
    tx_ready = 1'b1;
    bad = 0;
    send_byte(8'h12); send_byte(8'h2B);
    for (int i = 0; i < T - 1; i++) begin
      step();
      if (frame_err !== 1'b0 || tx_valid !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL timeout_early: got %0d bad idle cycles, expected 0", bad);
    end
    step();
    vectors++;
    if (frame_err !== 1'b1 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_fire: got err=%b v=%b, expected 1 0", frame_err, tx_valid);
    end
    step();
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse: got err=%b, expected 0", frame_err);
    end
    exp_q.push_back(8'h00); exp_q.push_back(8'h02);
    send_byte(8'h01); send_byte(8'h2B); send_byte(8'h01);
    drain("timeout_after");
    // Byte arriving on the limit cycle must win over the timeout.
    send_byte(8'h01); send_byte(8'h2B);
    repeat (T - 1) step();
    exp_q.push_back(8'h00); exp_q.push_back(8'h03);
    send_byte(8'h02);
    vectors++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_limit: got err=%b busy=%b, expected 0 1", frame_err, busy);
    end
    drain("timeout_limit");
  endtask

  task automatic test_backpressure();
    int unstable;
    tx_ready = 1'b0;
    unstable = 0;
    exp_q.push_back(8'h00); exp_q.push_back(8'h30);
    send_byte(8'hF0); send_byte(8'h26); send_byte(8'h3C);
    step();
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        rx_data = 8'h99; rx_valid = 1'b1;
      end
      step();
      rx_valid = 1'b0;
      if (i == 10) begin
        vectors++;
        if (ovr !== 1'b1) begin
          miscompares++;
          $display("FAIL bp_ovr: got %b, expected 1", ovr);
        end
      end
      if (i == 11) begin
        vectors++;
        if (ovr !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_ovr_pulse: got %b, expected 0", ovr);
        end
      end
      if (tx_valid !== 1'b1 || tx_data !== 8'h00) unstable++;
    end
    vectors++;
    if (unstable != 0) begin
      miscompares++;
      $display("FAIL bp_hold: got %0d unstable cycles, expected 0", unstable);
    end
    tx_ready = 1'b1;
    drain("bp");
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'h0A);
    send_byte(8'h05); send_byte(8'h2B); send_byte(8'h05);
    step(); step();
    send_byte(8'h55);
    vectors++;
    if (ovr !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_final: got ovr=%b busy=%b v=%b, expected 1 0 0", ovr, busy, tx_valid);
    end
    exp_q.push_back(8'h00); exp_q.push_back(8'h0C);
    send_byte(8'h03); send_byte(8'h2A); send_byte(8'h04);
    drain("b2b_next");
  endtask

  task automatic test_reset_mid_send();
    tx_ready = 1'b1;
    exp_q.push_back(8'h00);
    send_byte(8'h07); send_byte(8'h7C); send_byte(8'h08);
    step(); step();
    tx_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: got v=%b busy=%b, expected 0 0", tx_valid, busy);
    end
    step();
    rst = 1'b0;
    step();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rst_hi_sent: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    tx_ready = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'h0F);
    send_byte(8'h07); send_byte(8'h7C); send_byte(8'h08);
    drain("rst_next");
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_arith();
    test_bad_opcode();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
